// File: rtl/regfile_fwd.sv
// Purpose: GPR file with two combinational read ports, one WB write port and an EX/MEM/WB bypass network.
// Latency: reads are zero-latency (combinational); a write lands in the array on the next rising clk edge.
// Backpressure: none; the block never stalls, and load-use hazards are resolved upstream.
module regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata
);

    logic [DATA_W-1:0] r_mem [NREG];

    // A source whose destination is r0 carries no architectural value, so it never forwards.
    logic w_ex_fwd;
    logic w_mem_fwd;
    logic w_wb_fwd;

    assign w_ex_fwd  = ex_we  && (ex_waddr  != '0);
    assign w_mem_fwd = mem_we && (mem_waddr != '0);
    assign w_wb_fwd  = we     && (waddr     != '0);

    // Both read ports share one description, indexed by port number.
    logic [1:0]             w_re;
    logic [1:0][ADDR_W-1:0] w_raddr;
    logic [1:0][DATA_W-1:0] w_rdata;

    assign w_re    = {re2, re1};
    assign w_raddr = {raddr2, raddr1};
    assign rdata1  = w_rdata[0];
    assign rdata2  = w_rdata[1];

    // Array update: reset clears every entry and wins over a same-cycle write; r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wb_fwd) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] w_arr;
        assign w_arr = r_mem[w_raddr[p]];

        // Read mux: youngest producer first (EX, then MEM, then WB write-through), array last.
        always_comb begin
            w_rdata[p] = '0;
            if (rst || !w_re[p] || (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
            end else if (w_ex_fwd && (ex_waddr == w_raddr[p])) begin
                w_rdata[p] = ex_wdata;
            end else if (w_mem_fwd && (mem_waddr == w_raddr[p])) begin
                w_rdata[p] = mem_wdata;
            end else if (w_wb_fwd && (waddr == w_raddr[p])) begin
                w_rdata[p] = wdata;
            end else begin
                w_rdata[p] = w_arr;
            end
        end
    end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Architectural general-purpose register file for the five-stage pipeline.
- It is the source side of the operands the execute stage consumes, and the sink of the results that execute produces.
- Two combinational read ports feed ID, which forwards the values to EX as rdata1/rdata2. One synchronous write port is driven by WB.
- A built-in bypass network resolves RAW hazards from the EX, MEM and WB stages, so ID always sees the newest value.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (must equal 2**ADDR_W).

Ports:
- clk  input  1  pipeline clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- we  input  1  WB write enable.
- waddr  input  ADDR_W  WB destination register.
- wdata  input  DATA_W  WB write data.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1.
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2.
- ex_we  input  1  write enable of the instruction currently in EX.
- ex_waddr  input  ADDR_W  destination register of the instruction currently in EX.
- ex_wdata  input  DATA_W  result of the instruction currently in EX.
- mem_we  input  1  write enable of the instruction currently in MEM.
- mem_waddr  input  ADDR_W  destination register of the instruction currently in MEM.
- mem_wdata  input  DATA_W  result of the instruction currently in MEM.

Behaviour:
- Storage: NREG x DATA_W array. Register 0 is hardwired to zero: never written, always reads 0.
- Reset:
  - rst=1 asynchronously clears every array entry to 0.
  - While rst=1, rdata1 and rdata2 are forced to 0 and writes are ignored.
  - Deassertion takes effect with no extra latency; the first write can occur at the next rising edge after deassertion.
  - Reset asserted mid-write (same cycle as we=1) wins: the entry stays 0.
- Write:
  - On the rising clk edge, if we=1 and waddr!=0, then array[waddr] <= wdata.
  - A write to address 0 is silently dropped.
- Read (combinational, zero latency), port n:
  - If rst=1, re_n=0, or raddr_n=0, rdata_n is 0.
  - Otherwise, with priority from highest to lowest:
    1. ex_we=1 and ex_waddr==raddr_n: ex_wdata.
    2. mem_we=1 and mem_waddr==raddr_n: mem_wdata.
    3. we=1 and waddr==raddr_n: wdata (write-through in the same cycle as the write).
    4. Otherwise: array[raddr_n].
- Forwarding sources with address 0 never forward, even when their enable is 1.
- The two ports are independent. Both may read the same address and must then return identical values.
- No stall is generated: load-use hazards are handled outside this block. The bypass only returns whatever value the matching stage presents.
- Width rules: all data paths are DATA_W bits; no sign or zero extension inside the block.

Test Plan:
1. Reset check: assert rst, then deassert. Read addresses 1..31 on both ports with re1=re2=1 -> all rdata are 0x00000000.
2. Write then read: cycle 0 we=1, waddr=5, wdata=0x1234ABCD. Cycle 1 re1=1, raddr1=5, all bypass enables 0 -> rdata1=0x1234ABCD.
3. Register 0 protection:
   - we=1, waddr=0, wdata=0xFFFFFFFF, then read raddr1=0 -> rdata1=0.
   - ex_we=1, ex_waddr=0, ex_wdata=0xDEAD0000 with raddr2=0 -> rdata2=0.
4. Bypass priority:
   - array[7]=0x11. Same cycle: we=1/waddr=7/wdata=0x22, mem_we=1/mem_waddr=7/mem_wdata=0x33, ex_we=1/ex_waddr=7/ex_wdata=0x44, raddr1=raddr2=7 -> both rdata are 0x44.
   - Drop ex_we -> both 0x33.
   - Drop mem_we -> both 0x22.
   - Next cycle, all enables 0 -> both 0x22 (value now in the array).
5. Read enable gating: array[3]=0x55, re1=0, raddr1=3 -> rdata1=0. Raise re1=1 -> rdata1=0x55 in the same cycle.
6. Asynchronous reset mid-operation:
   - array[9]=0xA5A5A5A5. Assert rst between clock edges -> rdata1 (raddr1=9, re1=1) drops to 0 immediately.
   - Deassert, then read 9 -> 0.
   - A write of 0x77 to 9 issued in the same cycle as rst=1 is lost -> 9 still reads 0.
